// File: rtl/fft8_pkg.sv
// Shared widths, twiddle table and FSM states for the 8-point FFT sequencer.
package fft8_pkg;

  localparam int IW    = 12;
  localparam int QW    = 14;
  localparam int OW    = 20;
  localparam int SCALE = 10;

  localparam logic signed [4:0] W_R [0:3] = '{
    5'sd10, 5'sd7, 5'sd0, -5'sd7
  };
  localparam logic signed [4:0] W_I [0:3] = '{
    5'sd0, -5'sd7, -5'sd10, -5'sd7
  };

  typedef enum logic [1:0] {
    LOAD,
    BFLY,
    TWID,
    OUT
  } state_e;

  function automatic logic signed [QW-1:0] sx_q(
    input logic signed [IW-1:0] v
  );
    return {{(QW-IW){v[IW-1]}}, v};
  endfunction

  function automatic logic signed [OW-1:0] sx_o(
    input logic signed [QW-1:0] v
  );
    return {{(OW-QW){v[QW-1]}}, v};
  endfunction

endpackage

// File: rtl/fft8_cmul.sv
// Combinational complex multiply of an odd sub-FFT bin by the x10 twiddle W_k.
import fft8_pkg::*;

module fft8_cmul (
  input  logic signed [QW-1:0] q_re,
  input  logic signed [QW-1:0] q_im,
  input  logic        [1:0]    k,
  output logic signed [OW-1:0] m_re,
  output logic signed [OW-1:0] m_im
);

  logic signed [OW-1:0] wr;
  logic signed [OW-1:0] wi;
  logic signed [OW-1:0] qr;
  logic signed [OW-1:0] qi;

  always_comb begin
    wr   = {{(OW-5){W_R[k][4]}}, W_R[k]};
    wi   = {{(OW-5){W_I[k][4]}}, W_I[k]};
    qr   = sx_o(q_re);
    qi   = sx_o(q_im);
    m_re = wr * qr - wi * qi;
    m_im = wr * qi + wi * qr;
  end

endmodule

// File: rtl/fft8_seq.sv
// Serial-in/serial-out 8-point DIT FFT: load, 4-point butterflies,
// time-shared twiddle multiply, then natural-order output of 10x bins.
import fft8_pkg::*;

module fft8_seq (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic        [2:0]    out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam logic signed [OW-1:0] TEN = OW'(SCALE);

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic busy_q, busy_d;

  logic signed [IW-1:0] x_q [8];
  logic signed [IW-1:0] x_d [8];

  logic signed [QW-1:0] s_re_q [4];
  logic signed [QW-1:0] s_im_q [4];
  logic signed [QW-1:0] q_re_q [4];
  logic signed [QW-1:0] q_im_q [4];
  logic signed [QW-1:0] s_re_d [4];
  logic signed [QW-1:0] s_im_d [4];
  logic signed [QW-1:0] q_re_d [4];
  logic signed [QW-1:0] q_im_d [4];

  logic signed [OW-1:0] m_re_q [4];
  logic signed [OW-1:0] m_im_q [4];
  logic signed [OW-1:0] m_re_d [4];
  logic signed [OW-1:0] m_im_d [4];

  logic signed [QW-1:0] e0, e1, e2, e3;
  logic signed [QW-1:0] o0, o1, o2, o3;
  logic signed [OW-1:0] cm_re, cm_im;
  logic signed [OW-1:0] s10_re, s10_im;
  logic [1:0] k;

  assign k = cnt_q[1:0];

  fft8_cmul u_cmul (
    .q_re (q_re_q[k]),
    .q_im (q_im_q[k]),
    .k    (k),
    .m_re (cm_re),
    .m_im (cm_im)
  );

  always_comb begin
    e0 = sx_q(x_q[0]);
    e1 = sx_q(x_q[2]);
    e2 = sx_q(x_q[4]);
    e3 = sx_q(x_q[6]);
    o0 = sx_q(x_q[1]);
    o1 = sx_q(x_q[3]);
    o2 = sx_q(x_q[5]);
    o3 = sx_q(x_q[7]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    s_re_d  = s_re_q;
    s_im_d  = s_im_q;
    q_re_d  = q_re_q;
    q_im_d  = q_im_q;
    m_re_d  = m_re_q;
    m_im_d  = m_im_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          x_d[cnt_q] = in_data;
          cnt_d      = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = BFLY;
        end
      end
      BFLY: begin
        s_re_d[0] = e0 + e1 + e2 + e3;
        s_im_d[0] = '0;
        s_re_d[1] = e0 - e2;
        s_im_d[1] = e3 - e1;
        s_re_d[2] = e0 - e1 + e2 - e3;
        s_im_d[2] = '0;
        s_re_d[3] = e0 - e2;
        s_im_d[3] = e1 - e3;
        q_re_d[0] = o0 + o1 + o2 + o3;
        q_im_d[0] = '0;
        q_re_d[1] = o0 - o2;
        q_im_d[1] = o3 - o1;
        q_re_d[2] = o0 - o1 + o2 - o3;
        q_im_d[2] = '0;
        q_re_d[3] = o0 - o2;
        q_im_d[3] = o1 - o3;
        cnt_d     = '0;
        state_d   = TWID;
      end
      TWID: begin
        m_re_d[k] = cm_re;
        m_im_d[k] = cm_im;
        if (k == 2'd3) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    busy_d = (state_d != LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 8; i++) x_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        s_re_q[i] <= '0;
        s_im_q[i] <= '0;
        q_re_q[i] <= '0;
        q_im_q[i] <= '0;
        m_re_q[i] <= '0;
        m_im_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      x_q     <= x_d;
      s_re_q  <= s_re_d;
      s_im_q  <= s_im_d;
      q_re_q  <= q_re_d;
      q_im_q  <= q_im_d;
      m_re_q  <= m_re_d;
      m_im_q  <= m_im_d;
    end
  end

  // Upper half of the spectrum reuses the same S/M pair with M negated.
  always_comb begin
    s10_re    = sx_o(s_re_q[k]) * TEN;
    s10_im    = sx_o(s_im_q[k]) * TEN;
    out_re    = '0;
    out_im    = '0;
    out_idx   = '0;
    out_valid = 1'b0;
    if (state_q == OUT) begin
      out_valid = 1'b1;
      out_idx   = cnt_q;
      if (cnt_q[2]) begin
        out_re = s10_re - m_re_q[k];
        out_im = s10_im - m_im_q[k];
      end else begin
        out_re = s10_re + m_re_q[k];
        out_im = s10_im + m_im_q[k];
      end
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = busy_q;

endmodule

// File: tb/tb_fft8_seq.sv
// Randomised and directed checks of fft8_seq against a 4-point-DFT
// decomposition model with the x10 twiddle table.
module tb_fft8_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] out_re;
  logic signed [19:0] out_im;
  logic        [2:0]  out_idx;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_re [8];
  int exp_im [8];
  int got_re [8];
  int got_im [8];

  fft8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Y_k = 10*E_k +/- W_k*O_k, with E/O the exact 4-point DFTs (powers of -j).
  task automatic model(input int x [8]);
    int jr [4] = '{1, 0, -1, 0};
    int ji [4] = '{0, -1, 0, 1};
    int wr [4] = '{10, 7, 0, -7};
    int wi [4] = '{0, -7, -10, -7};
    for (int kk = 0; kk < 4; kk++) begin
      int er = 0, ei = 0, orr = 0, oi = 0, mr, mi, p;
      for (int m = 0; m < 4; m++) begin
        p = (m * kk) % 4;
        er  += x[2*m] * jr[p];
        ei  += x[2*m] * ji[p];
        orr += x[2*m+1] * jr[p];
        oi  += x[2*m+1] * ji[p];
      end
      mr = wr[kk] * orr - wi[kk] * oi;
      mi = wr[kk] * oi + wi[kk] * orr;
      exp_re[kk]   = 10 * er + mr;
      exp_im[kk]   = 10 * ei + mi;
      exp_re[kk+4] = 10 * er - mr;
      exp_im[kk+4] = 10 * ei - mi;
    end
  endtask

  task automatic send(input int v);
    int t = 0;
    in_valid = 1'b1;
    in_data  = 12'(v);
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_wait", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_frame(input int x [8], input int gap_at,
                          input int stall_at, input bit chk_lat);
    int lat = 0;
    model(x);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("gap_no_ready_drop", int'(in_ready), 1);
      end
      send(x[i]);
    end
    chk("busy_after_e0", int'(busy), 1);
    chk("in_ready_after_e0", int'(in_ready), 0);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (chk_lat) chk("latency", lat, 5);
    for (int kk = 0; kk < 8; kk++) begin
      if (kk == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk($sformatf("stall_idx%0d", kk), int'(out_idx), kk);
          chk($sformatf("stall_re%0d", kk), int'(out_re), exp_re[kk]);
          chk($sformatf("stall_im%0d", kk), int'(out_im), exp_im[kk]);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      chk($sformatf("valid%0d", kk), int'(out_valid), 1);
      chk($sformatf("idx%0d", kk), int'(out_idx), kk);
      chk($sformatf("re%0d", kk), int'(out_re), exp_re[kk]);
      chk($sformatf("im%0d", kk), int'(out_im), exp_im[kk]);
      got_re[kk] = int'(out_re);
      got_im[kk] = int'(out_im);
      @(posedge clk); #1;
    end
    chk("busy_end", int'(busy), 0);
    chk("in_ready_end", int'(in_ready), 1);
    chk("valid_end", int'(out_valid), 0);
  endtask

  initial begin
    int x [8];
    int imp0 [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int imp1 [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    int ex   [8] = '{10, 4, -3, 5, -10, 9, -13, -11};
    int c1r  [8] = '{10, 7, 0, -7, -10, -7, 0, 7};
    int c1i  [8] = '{0, -7, -10, -7, 0, 7, 10, 7};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_frame(imp0, -1, -1, 1'b1);
    for (int kk = 0; kk < 8; kk++) begin
      chk($sformatf("imp0_re%0d", kk), got_re[kk], 10);
      chk($sformatf("imp0_im%0d", kk), got_im[kk], 0);
    end

    do_frame(imp1, -1, -1, 1'b1);
    for (int kk = 0; kk < 8; kk++) begin
      chk($sformatf("imp1_re%0d", kk), got_re[kk], c1r[kk]);
      chk($sformatf("imp1_im%0d", kk), got_im[kk], c1i[kk]);
    end

    do_frame(ex, -1, -1, 1'b1);
    chk("ex_y0_re", got_re[0], -90);
    chk("ex_y0_im", got_im[0], 0);
    chk("ex_y4_re", got_re[4], -230);
    chk("ex_y4_im", got_im[4], 0);

    for (int i = 0; i < 8; i++) x[i] = -2048;
    do_frame(x, -1, -1, 1'b1);
    chk("fs_y0_re", got_re[0], -163840);
    chk("fs_y0_im", got_im[0], 0);
    chk("fs_y4_re", got_re[4], 0);

    do_frame(ex, 3, 2, 1'b0);

    for (int i = 0; i < 5; i++)
      send(int'($urandom_range(0, 4095)) - 2048);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_frame(imp0, -1, -1, 1'b1);
    for (int kk = 0; kk < 8; kk++)
      chk($sformatf("postrst_re%0d", kk), got_re[kk], 10);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 8; i++)
        x[i] = int'($urandom_range(0, 4095)) - 2048;
      do_frame(x, int'($urandom_range(0, 9)),
               int'($urandom_range(0, 9)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
